regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (A3/WD3/WE) between two write-back requesters: requester 0 is ALU result, requester 1 is load data.
- Round-robin arbitration with a valid/ready handshake per requester.
- One registered output stage drives the regFile write port directly.
- Exports a pending-write mask so decode can stall on read-after-write hazards.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width (32 registers)
- CNT_W, 16, width of the conflict counter (optional feature)

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- STALL  in  1  freeze: no new grants while high
- REQ0_VALID  in  1  requester 0 has a write
- REQ0_ADDR  in  ADDR_W  requester 0 destination register
- REQ0_DATA  in  DATA_W  requester 0 write data
- REQ0_READY  out  1  requester 0 write accepted this cycle
- REQ1_VALID / REQ1_ADDR / REQ1_DATA / REQ1_READY  same as requester 0, for requester 1
- A3  out  ADDR_W  regFile write address
- WD3  out  DATA_W  regFile write data
- WE  out  1  regFile write enable
- PEND_MASK  out  32  bit i set = write to register i is presented on the port this cycle
- CONFLICT_CNT  out  CNT_W  cycles in which one valid requester was refused (optional feature)

Behaviour:
- Reset (RST_N low, asynchronous): WE=0, A3=0, WD3=0, PEND_MASK=0, CONFLICT_CNT=0, LAST=1. With LAST=1, requester 0 wins the first conflict.
- Handshake:
  - A transfer occurs on a cycle with VALIDn=1 and READYn=1.
  - READYn is combinational from the VALIDs, STALL and LAST.
  - At most one READY is high per cycle.
  - A requester holds VALID, ADDR and DATA stable until accepted.
- Grant rules:
  - STALL=1: no grant; both READY=0.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester not equal to LAST is granted.
  - LAST updates to the granted index on every grant.
- Output stage (registered, 1-cycle latency):
  - Grant with ADDR≠0: next edge loads A3=ADDR, WD3=DATA, WE=1.
  - Grant with ADDR=0: the write is accepted (READY=1) but discarded. Next edge WE=0; A3/WD3 hold.
  - No grant: next edge WE=0; A3/WD3 hold their last values.
- The regFile always consumes a write, so the stage never backs up. Sustained throughput is one write per cycle.
- PEND_MASK: equals 1<<A3 when WE=1, else 0. Bit 0 is always 0.
- Same-register writes from both requesters in one cycle: serialized in grant order. The later write lands one cycle later and wins.
- STALL asserted while WE=1: the in-flight write still completes. WE drops the following cycle.
- Reset mid-operation: the in-flight write is dropped (WE forced 0 immediately), and LAST returns to 1.

Optional Feature:
- Macro: WBARB_CONFLICT_CNT_EN
- Defined:
  - CONFLICT_CNT increments on each cycle with STALL=0 where both VALIDs are high.
  - Saturates at 2^CNT_W−1.
  - Cleared only by reset.
- Undefined:
  - No counter logic is built.
  - CONFLICT_CNT port remains and is tied to 0.

Test Plan:
- Reset then REQ0 valid alone, ADDR=3, DATA=0xFFFFFFFF -> REQ0_READY=1 the same cycle; next cycle WE=1, A3=3, WD3=0xFFFFFFFF, PEND_MASK=0x00000008; the following cycle WE=0.
- Both valid from reset, REQ0 (ADDR=5, DATA=0x11), REQ1 (ADDR=6, DATA=0x22), held until accepted -> REQ0 granted in cycle 0 and REQ1 in cycle 1. WE=1 on two consecutive cycles with A3=5 then 6. CONFLICT_CNT=1 when the feature is enabled.
- Both requesters continuously valid for 8 cycles with fresh data each transfer -> grants alternate 0,1,0,1,…; each requester gets 4 grants; WE stays high throughout.
- REQ1 ADDR=0, DATA=0xDEAD -> REQ1_READY=1; next cycle WE=0 and PEND_MASK=0; A3/WD3 unchanged.
- STALL=1 with both valid for 3 cycles -> both READY=0, WE=0 after the in-flight write, CONFLICT_CNT unchanged; on STALL release the correct round-robin order resumes.
- RST_N pulsed low while WE=1 (A3=7) -> WE=0 and PEND_MASK=0 immediately, without waiting for a clock edge; after release, a conflict grants REQ0 first.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing the regFile write port between ALU (0) and load (1).
// Optional conflict counter built only when WBARB_CONFLICT_CNT_EN is defined.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              STALL,
  input  logic              REQ0_VALID,
  input  logic [ADDR_W-1:0] REQ0_ADDR,
  input  logic [DATA_W-1:0] REQ0_DATA,
  output logic              REQ0_READY,
  input  logic              REQ1_VALID,
  input  logic [ADDR_W-1:0] REQ1_ADDR,
  input  logic [DATA_W-1:0] REQ1_DATA,
  output logic              REQ1_READY,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  output logic              WE,
  output logic [31:0]       PEND_MASK,
  output logic [CNT_W-1:0]  CONFLICT_CNT
);

  logic              last;
  logic              gnt_any;
  logic [ADDR_W-1:0] gnt_addr;
  logic [DATA_W-1:0] gnt_data;

  // On conflict the requester that did not win last time goes first.
  always_comb begin
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    if (!STALL) begin
      REQ0_READY = REQ0_VALID && (!REQ1_VALID || last);
      REQ1_READY = REQ1_VALID && (!REQ0_VALID || !last);
    end
  end

  assign gnt_any  = REQ0_READY | REQ1_READY;
  assign gnt_addr = REQ1_READY ? REQ1_ADDR : REQ0_ADDR;
  assign gnt_data = REQ1_READY ? REQ1_DATA : REQ0_DATA;

  // Writes to r0 are accepted but never reach the port; A3/WD3 hold otherwise.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      last <= 1'b1;
      WE   <= 1'b0;
      A3   <= '0;
      WD3  <= '0;
    end else begin
      WE <= 1'b0;
      if (gnt_any) begin
        last <= REQ1_READY;
        if (gnt_addr != '0) begin
          WE  <= 1'b1;
          A3  <= gnt_addr;
          WD3 <= gnt_data;
        end
      end
    end
  end

  assign PEND_MASK = (WE && A3 != '0) ? (32'd1 << A3) : 32'd0;

`ifdef WBARB_CONFLICT_CNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      CONFLICT_CNT <= '0;
    else if (!STALL && REQ0_VALID && REQ1_VALID && CONFLICT_CNT != '1)
      CONFLICT_CNT <= CONFLICT_CNT + 1'b1;
  end
`else
  assign CONFLICT_CNT = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: handshake, round-robin order, r0 discard, stall, async reset.
module tb_regfile_wb_arbiter;
  logic        CLK, RST_N, STALL;
  logic        REQ0_VALID, REQ0_READY, REQ1_VALID, REQ1_READY;
  logic [4:0]  REQ0_ADDR, REQ1_ADDR, A3;
  logic [31:0] REQ0_DATA, REQ1_DATA, WD3, PEND_MASK;
  logic        WE;
  logic [15:0] CONFLICT_CNT;

  int tests = 0;
  int fails = 0;
  int exp_cnt = 0;

  regfile_wb_arbiter dut (
    .CLK(CLK), .RST_N(RST_N), .STALL(STALL),
    .REQ0_VALID(REQ0_VALID), .REQ0_ADDR(REQ0_ADDR), .REQ0_DATA(REQ0_DATA), .REQ0_READY(REQ0_READY),
    .REQ1_VALID(REQ1_VALID), .REQ1_ADDR(REQ1_ADDR), .REQ1_DATA(REQ1_DATA), .REQ1_READY(REQ1_READY),
    .A3(A3), .WD3(WD3), .WE(WE), .PEND_MASK(PEND_MASK), .CONFLICT_CNT(CONFLICT_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    STALL = 0; REQ0_VALID = 0; REQ1_VALID = 0;
    REQ0_ADDR = 0; REQ0_DATA = 0; REQ1_ADDR = 0; REQ1_DATA = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge CLK);
    RST_N = 0;
    #2;
    RST_N = 1;
    exp_cnt = 0;
    step();
  endtask

  function automatic logic [15:0] cnt_exp();
`ifdef WBARB_CONFLICT_CNT_EN
    return 16'(exp_cnt);
`else
    return 16'd0;
`endif
  endfunction

  task automatic test_reset();
    idle_inputs();
    RST_N = 0;
    #3;
    tests++;
    if ({WE, A3, WD3, PEND_MASK, CONFLICT_CNT} !== 86'd0) begin
      fails++;
      $display("FAIL reset_state got WE=%b A3=%0d WD3=%h PEND=%h CNT=%0d want all 0", WE, A3, WD3, PEND_MASK, CONFLICT_CNT);
    end
    tests++;
    if ({REQ0_READY, REQ1_READY} !== 2'b00) begin
      fails++;
      $display("FAIL reset_ready got %b%b want 00", REQ0_READY, REQ1_READY);
    end
    RST_N = 1;
    exp_cnt = 0;
    step();
  endtask

  task automatic test_single_write();
    REQ0_VALID = 1; REQ0_ADDR = 3; REQ0_DATA = 32'hFFFF_FFFF;
    #1;
    tests++;
    if ({REQ0_READY, REQ1_READY} !== 2'b10) begin
      fails++;
      $display("FAIL single_ready got %b%b want 10", REQ0_READY, REQ1_READY);
    end
    step();
    REQ0_VALID = 0;
    tests++;
    if ({WE, A3, WD3, PEND_MASK} !== {1'b1, 5'd3, 32'hFFFF_FFFF, 32'h0000_0008}) begin
      fails++;
      $display("FAIL single_write got WE=%b A3=%0d WD3=%h PEND=%h want 1 3 ffffffff 00000008", WE, A3, WD3, PEND_MASK);
    end
    step();
    tests++;
    if ({WE, PEND_MASK, A3} !== {1'b0, 32'd0, 5'd3}) begin
      fails++;
      $display("FAIL single_after got WE=%b PEND=%h A3=%0d want 0 0 3", WE, PEND_MASK, A3);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    REQ0_VALID = 1; REQ0_ADDR = 5; REQ0_DATA = 32'h11;
    REQ1_VALID = 1; REQ1_ADDR = 6; REQ1_DATA = 32'h22;
    #1;
    tests++;
    if ({REQ0_READY, REQ1_READY} !== 2'b10) begin
      fails++;
      $display("FAIL conflict_first_ready got %b%b want 10", REQ0_READY, REQ1_READY);
    end
    exp_cnt++;
    step();
    REQ0_VALID = 0;
    #1;
    tests++;
    if ({WE, A3, WD3, REQ1_READY} !== {1'b1, 5'd5, 32'h11, 1'b1}) begin
      fails++;
      $display("FAIL conflict_first_write got WE=%b A3=%0d WD3=%h R1=%b want 1 5 11 1", WE, A3, WD3, REQ1_READY);
    end
    step();
    REQ1_VALID = 0;
    tests++;
    if ({WE, A3, WD3, PEND_MASK} !== {1'b1, 5'd6, 32'h22, 32'h40}) begin
      fails++;
      $display("FAIL conflict_second_write got WE=%b A3=%0d WD3=%h PEND=%h want 1 6 22 40", WE, A3, WD3, PEND_MASK);
    end
    tests++;
    if (CONFLICT_CNT !== cnt_exp()) begin
      fails++;
      $display("FAIL conflict_cnt got %0d want %0d", CONFLICT_CNT, cnt_exp());
    end
    step();
  endtask

  // LAST is 1 on entry (previous grant went to requester 1), so requester 0 leads.
  task automatic test_back_to_back();
    int k0 = 0, k1 = 0, g0 = 0, g1 = 0, g;
    REQ0_VALID = 1; REQ0_ADDR = 10; REQ0_DATA = 32'h100;
    REQ1_VALID = 1; REQ1_ADDR = 20; REQ1_DATA = 32'h200;
    for (int i = 0; i < 8; i++) begin
      g = i % 2;
      #1;
      tests++;
      if ({REQ0_READY, REQ1_READY} !== (g == 0 ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL b2b_ready[%0d] got %b%b want grant %0d", i, REQ0_READY, REQ1_READY, g);
      end
      exp_cnt++;
      step();
      tests++;
      if ({WE, A3, WD3} !== {1'b1, (g == 0 ? 5'd10 : 5'd20), (g == 0 ? 32'h100 + 32'(k0) : 32'h200 + 32'(k1))}) begin
        fails++;
        $display("FAIL b2b_write[%0d] got WE=%b A3=%0d WD3=%h", i, WE, A3, WD3);
      end
      if (g == 0) begin k0++; g0++; REQ0_DATA = 32'h100 + 32'(k0); end
      else begin k1++; g1++; REQ1_DATA = 32'h200 + 32'(k1); end
    end
    REQ0_VALID = 0; REQ1_VALID = 0;
    tests++;
    if (g0 != 4 || g1 != 4 || CONFLICT_CNT !== cnt_exp()) begin
      fails++;
      $display("FAIL b2b_totals got g0=%0d g1=%0d CNT=%0d want 4 4 %0d", g0, g1, CONFLICT_CNT, cnt_exp());
    end
    step();
  endtask

  task automatic test_addr_zero();
    REQ1_VALID = 1; REQ1_ADDR = 0; REQ1_DATA = 32'hDEAD;
    #1;
    tests++;
    if ({REQ0_READY, REQ1_READY} !== 2'b01) begin
      fails++;
      $display("FAIL r0_ready got %b%b want 01", REQ0_READY, REQ1_READY);
    end
    step();
    REQ1_VALID = 0;
    tests++;
    if ({WE, PEND_MASK, A3, WD3} !== {1'b0, 32'd0, 5'd20, 32'h203}) begin
      fails++;
      $display("FAIL r0_discard got WE=%b PEND=%h A3=%0d WD3=%h want 0 0 20 203", WE, PEND_MASK, A3, WD3);
    end
    step();
  endtask

  // LAST=1 on entry; the lone write to r4 flips it to 0, so requester 1 resumes first.
  task automatic test_stall();
    REQ0_VALID = 1; REQ0_ADDR = 4; REQ0_DATA = 32'h44;
    step();
    STALL = 1;
    REQ0_ADDR = 12; REQ0_DATA = 32'hC0;
    REQ1_VALID = 1; REQ1_ADDR = 13; REQ1_DATA = 32'hD0;
    #1;
    tests++;
    if ({WE, A3, WD3, REQ0_READY, REQ1_READY} !== {1'b1, 5'd4, 32'h44, 2'b00}) begin
      fails++;
      $display("FAIL stall_inflight got WE=%b A3=%0d WD3=%h RDY=%b%b want 1 4 44 00", WE, A3, WD3, REQ0_READY, REQ1_READY);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      tests++;
      if ({WE, REQ0_READY, REQ1_READY, CONFLICT_CNT} !== {3'b000, cnt_exp()}) begin
        fails++;
        $display("FAIL stall_hold[%0d] got WE=%b RDY=%b%b CNT=%0d want 0 00 %0d", i, WE, REQ0_READY, REQ1_READY, CONFLICT_CNT, cnt_exp());
      end
    end
    STALL = 0;
    #1;
    tests++;
    if ({REQ0_READY, REQ1_READY} !== 2'b01) begin
      fails++;
      $display("FAIL stall_resume_ready got %b%b want 01", REQ0_READY, REQ1_READY);
    end
    exp_cnt++;
    step();
    REQ1_VALID = 0;
    #1;
    tests++;
    if ({WE, A3, WD3, REQ0_READY} !== {1'b1, 5'd13, 32'hD0, 1'b1}) begin
      fails++;
      $display("FAIL stall_resume_1 got WE=%b A3=%0d WD3=%h R0=%b want 1 13 d0 1", WE, A3, WD3, REQ0_READY);
    end
    step();
    REQ0_VALID = 0;
    tests++;
    if ({WE, A3, WD3, CONFLICT_CNT} !== {1'b1, 5'd12, 32'hC0, cnt_exp()}) begin
      fails++;
      $display("FAIL stall_resume_0 got WE=%b A3=%0d WD3=%h CNT=%0d want 1 12 c0 %0d", WE, A3, WD3, CONFLICT_CNT, cnt_exp());
    end
    step();
  endtask

  // Finishes with a conflict after reset: requester 1 won last, yet reset must hand it back to 0.
  task automatic test_reset_mid();
    REQ1_VALID = 1; REQ1_ADDR = 7; REQ1_DATA = 32'h77;
    step();
    REQ1_VALID = 0;
    tests++;
    if ({WE, A3, PEND_MASK} !== {1'b1, 5'd7, 32'h80}) begin
      fails++;
      $display("FAIL rstmid_pre got WE=%b A3=%0d PEND=%h want 1 7 80", WE, A3, PEND_MASK);
    end
    #2;
    RST_N = 0;
    #1;
    tests++;
    if ({WE, PEND_MASK, A3, CONFLICT_CNT} !== 54'd0) begin
      fails++;
      $display("FAIL rstmid_async got WE=%b PEND=%h A3=%0d CNT=%0d want 0 0 0 0", WE, PEND_MASK, A3, CONFLICT_CNT);
    end
    @(negedge CLK);
    RST_N = 1;
    exp_cnt = 0;
    REQ0_VALID = 1; REQ0_ADDR = 8; REQ0_DATA = 32'h88;
    REQ1_VALID = 1; REQ1_ADDR = 9; REQ1_DATA = 32'h99;
    #1;
    tests++;
    if ({REQ0_READY, REQ1_READY} !== 2'b10) begin
      fails++;
      $display("FAIL rstmid_conflict got %b%b want 10", REQ0_READY, REQ1_READY);
    end
    step();
    idle_inputs();
    tests++;
    if ({WE, A3, WD3} !== {1'b1, 5'd8, 32'h88}) begin
      fails++;
      $display("FAIL rstmid_write got WE=%b A3=%0d WD3=%h want 1 8 88", WE, A3, WD3);
    end
    step();
  endtask

  initial begin
    RST_N = 1;
    idle_inputs();
    test_reset();
    test_single_write();
    test_conflict();
    test_back_to_back();
    test_addr_zero();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
